// File: rtl/ftransform_wht_pkg.sv
// Shared types and constants for the forward 4x4 Walsh-Hadamard transform of VP8 I16 luma DCs.
package ftransform_wht_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_ROW  = 2'd1,
      ST_COL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [3:0] LAST_BEAT = 4'd15;
   localparam logic [1:0] LAST_PASS = 2'd3;

endpackage

// File: rtl/ftransform_wht_if.sv
// Stream-in / packed-out bus of the forward WHT block.
interface ftransform_wht_if #(
   parameter int BIT_WIDTH = 8
);
   logic                            in_valid;
   logic                            in_ready;
   logic [BIT_WIDTH+7:0]            in_data;
   logic [(BIT_WIDTH+8)*16-1:0]     out;
   logic                            done;
   logic                            busy;

   modport master (
      output in_valid, in_data,
      input  in_ready, out, done, busy
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, out, done, busy
   );
endinterface

// File: rtl/ftransform_wht_butterfly.sv
// Combinational 4-point Hadamard butterfly; output grows by two bits over the input.
module ftransform_wht_butterfly #(
   parameter int IN_W = 12
) (
   input  logic signed [IN_W-1:0] x0,
   input  logic signed [IN_W-1:0] x1,
   input  logic signed [IN_W-1:0] x2,
   input  logic signed [IN_W-1:0] x3,
   output logic signed [IN_W+1:0] y0,
   output logic signed [IN_W+1:0] y1,
   output logic signed [IN_W+1:0] y2,
   output logic signed [IN_W+1:0] y3
);
   logic signed [IN_W:0] a0_s;
   logic signed [IN_W:0] a1_s;
   logic signed [IN_W:0] a2_s;
   logic signed [IN_W:0] a3_s;

   assign a0_s = (IN_W+1)'(x0) + (IN_W+1)'(x2);
   assign a1_s = (IN_W+1)'(x1) + (IN_W+1)'(x3);
   assign a2_s = (IN_W+1)'(x1) - (IN_W+1)'(x3);
   assign a3_s = (IN_W+1)'(x0) - (IN_W+1)'(x2);

   assign y0 = (IN_W+2)'(a0_s) + (IN_W+2)'(a1_s);
   assign y1 = (IN_W+2)'(a3_s) + (IN_W+2)'(a2_s);
   assign y2 = (IN_W+2)'(a3_s) - (IN_W+2)'(a2_s);
   assign y3 = (IN_W+2)'(a0_s) - (IN_W+2)'(a1_s);
endmodule

// File: rtl/ftransform_wht.sv
// Forward 4x4 WHT: collects 16 DC beats, runs a row pass then a column pass (one per cycle),
// and presents the halved results on a packed bus with a one-cycle done pulse.
module ftransform_wht
   import ftransform_wht_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int BLOCK_SIZE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   ftransform_wht_if.slave bus
);
   localparam int COEF_W = BIT_WIDTH + 8;
   localparam int IN_W   = BIT_WIDTH + 4;
   localparam int TMP_W  = IN_W + 2;
   localparam int BF_W   = TMP_W + 2;
   localparam int N_COEF = BLOCK_SIZE * BLOCK_SIZE;

   state_e                   state_r;
   logic [3:0]               count_r;
   logic [1:0]               pass_r;
   logic                     in_ready_r;
   logic                     done_r;
   logic                     busy_r;
   logic signed [IN_W-1:0]   in_buf_r [N_COEF];
   logic signed [TMP_W-1:0]  tmp_r    [N_COEF];
   logic signed [COEF_W-1:0] out_r    [N_COEF];

   logic signed [IN_W-1:0]   row_x_s [4];
   logic signed [TMP_W-1:0]  row_y_s [4];
   logic signed [TMP_W-1:0]  col_x_s [4];
   logic signed [BF_W-1:0]   col_y_s [4];
   logic                     unused_s;

   // Floor halving of a column result, sign-extended to the coefficient field.
   function automatic logic signed [COEF_W-1:0] half_floor(input logic signed [BF_W-1:0] v);
      half_floor = COEF_W'(v >>> 1);
   endfunction

   // Only the low IN_W bits of a beat carry the coefficient.
   assign unused_s = ^bus.in_data[COEF_W-1:IN_W];

   // Row r reads raster entries 4r..4r+3; column c reads c, c+4, c+8, c+12.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         row_x_s[i] = in_buf_r[{pass_r, 2'(i)}];
         col_x_s[i] = tmp_r[{2'(i), pass_r}];
      end
   end

   ftransform_wht_butterfly #(.IN_W(IN_W)) u_row_bfly (
      .x0(row_x_s[0]), .x1(row_x_s[1]), .x2(row_x_s[2]), .x3(row_x_s[3]),
      .y0(row_y_s[0]), .y1(row_y_s[1]), .y2(row_y_s[2]), .y3(row_y_s[3])
   );

   ftransform_wht_butterfly #(.IN_W(TMP_W)) u_col_bfly (
      .x0(col_x_s[0]), .x1(col_x_s[1]), .x2(col_x_s[2]), .x3(col_x_s[3]),
      .y0(col_y_s[0]), .y1(col_y_s[1]), .y2(col_y_s[2]), .y3(col_y_s[3])
   );

   // FSM, beat collection, row/column passes and the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_LOAD;
         count_r    <= 4'd0;
         pass_r     <= 2'd0;
         in_ready_r <= 1'b1;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         for (int k = 0; k < N_COEF; k++) begin
            in_buf_r[k] <= '0;
            tmp_r[k]    <= '0;
            out_r[k]    <= '0;
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_LOAD: begin
               if (bus.in_valid && in_ready_r) begin
                  in_buf_r[count_r] <= bus.in_data[IN_W-1:0];
                  count_r           <= count_r + 4'd1;
                  if (count_r == LAST_BEAT) begin
                     state_r    <= ST_ROW;
                     pass_r     <= 2'd0;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b1;
                  end
               end
            end
            ST_ROW: begin
               for (int k = 0; k < 4; k++) begin
                  tmp_r[{pass_r, 2'(k)}] <= row_y_s[k];
               end
               pass_r <= pass_r + 2'd1;
               if (pass_r == LAST_PASS) begin
                  state_r <= ST_COL;
               end
            end
            ST_COL: begin
               for (int k = 0; k < 4; k++) begin
                  out_r[{2'(k), pass_r}] <= half_floor(col_y_s[k]);
               end
               pass_r <= pass_r + 2'd1;
               if (pass_r == LAST_PASS) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r    <= ST_LOAD;
               count_r    <= 4'd0;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b0;
            end
            default: begin
               state_r    <= ST_LOAD;
               count_r    <= 4'd0;
               pass_r     <= 2'd0;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   // Pack the output register onto the bus, element k at bits [16k+15:16k].
   always_comb begin
      bus.out = '0;
      for (int k = 0; k < N_COEF; k++) begin
         bus.out[k*COEF_W +: COEF_W] = out_r[k];
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;
endmodule

// File: tb/tb_ftransform_wht.sv
// Self-checking bench for ftransform_wht: directed cases, flow control, resets and random blocks
// against a matrix-form Hadamard reference.
module tb_ftransform_wht;
   localparam int BW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ftransform_wht_if #(.BIT_WIDTH(BW)) bus ();

   ftransform_wht #(.BIT_WIDTH(BW), .BLOCK_SIZE(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int           n_cmp = 0;
   int           n_err = 0;
   int           blk [16];
   logic [255:0] got_out;
   logic [255:0] held_out = '0;
   logic [255:0] saved;
   int           done_cyc = 0;
   int           prev_cyc;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // out = floor((H * X * H^T) / 2) with H the butterfly's Hadamard ordering.
   function automatic logic [255:0] ref_wht(input int x [16]);
      int h [4][4];
      int s;
      logic [255:0] r;
      h = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
      r = '0;
      for (int j = 0; j < 4; j++) begin
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int rr = 0; rr < 4; rr++)
               for (int m = 0; m < 4; m++)
                  s += h[j][rr] * h[c][m] * x[4*rr+m];
            r[(4*j+c)*16 +: 16] = 16'(s >>> 1);
         end
      end
      return r;
   endfunction

   function automatic logic [255:0] const_vec(input int e0, input int rest);
      logic [255:0] r;
      for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'((k == 0) ? e0 : rest);
      return r;
   endfunction

   task automatic fill(input int v0, input int rest);
      for (int k = 0; k < 16; k++) blk[k] = (k == 0) ? v0 : rest;
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 16; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
   endtask

   // Starts at a negedge; returns at the negedge where the last beat is presented.
   task automatic send_block(input int nbeats, input bit gaps);
      int k = 0;
      int guard = 0;
      logic [3:0] junk;
      while (k < nbeats && guard < 2000) begin
         if (guard > 0) @(negedge clk);
         guard++;
         junk = 4'($urandom);
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = {junk, 12'h5A5};
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = {junk, 12'(blk[k])};
         end
         if (bus.in_valid && bus.in_ready) k++;
      end
      chk("beats_accepted", 256'(k), 256'(nbeats));
   endtask

   task automatic wait_done(input bit hold);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (hold) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0777;
            chk("ready_low_while_busy", 256'(bus.in_ready), 256'(0));
         end else begin
            bus.in_valid = 1'b0;
         end
         chk("ready_busy_exclusive", 256'(bus.in_ready & bus.busy), 256'(0));
         if (bus.done) begin
            seen     = 1'b1;
            got_out  = bus.out;
            done_cyc = cyc;
         end
      end
      chk("done_latency", 256'(n), 256'(9));
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("done_single_pulse", 256'({bus.done, bus.in_ready, bus.busy}), 256'(3'b010));
   endtask

   task automatic run_block(input string tag, input bit gaps, input bit hold);
      logic [255:0] e;
      e = ref_wht(blk);
      send_block(16, gaps);
      chk({tag, "_out_held"}, bus.out, held_out);
      wait_done(hold);
      chk({tag, "_out"}, got_out, e);
      held_out = e;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_flags"}, 256'({bus.in_ready, bus.done, bus.busy}), 256'(3'b100));
      chk({tag, "_out"}, bus.out, '0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      fill(0, 0);        run_block("zero", 1'b0, 1'b0);
      chk("zero_const", got_out, const_vec(0, 0));
      fill(16, 0);       run_block("single_dc", 1'b0, 1'b0);
      chk("single_dc_const", got_out, const_vec(8, 8));
      fill(1, 1);        run_block("flat", 1'b0, 1'b0);
      chk("flat_const", got_out, const_vec(8, 0));
      fill(-3, 0);       run_block("rounding", 1'b0, 1'b0);
      chk("rounding_const", got_out, const_vec(-2, -2));
      fill(2047, 2047);  run_block("max", 1'b0, 1'b0);
      chk("max_const", got_out, const_vec(16376, 0));
      fill(-2048, -2048); run_block("min", 1'b0, 1'b0);
      chk("min_const", got_out, const_vec(-16384, 0));

      fill_rand();
      run_block("gaps", 1'b1, 1'b0);
      saved = got_out;
      run_block("nogaps", 1'b0, 1'b0);
      chk("gaps_vs_nogaps", got_out, saved);

      fill_rand();
      run_block("hold_valid", 1'b0, 1'b1);
      fill_rand();
      run_block("after_hold", 1'b0, 1'b0);

      prev_cyc = done_cyc;
      fill_rand();
      run_block("b2b", 1'b0, 1'b0);
      chk("period", 256'(done_cyc - prev_cyc), 256'(25));

      // Reset after seven beats, then a fresh known block.
      fill_rand();
      send_block(7, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("rst_load");
      rst_n = 1'b1;
      held_out = '0;
      fill(100, -7); blk[5] = 2047; blk[10] = -2048;
      run_block("after_rst_load", 1'b0, 1'b0);

      // Reset during the row pass.
      fill_rand();
      send_block(16, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("rst_row");
      rst_n = 1'b1;
      held_out = '0;
      fill_rand();
      run_block("after_rst_row", 1'b0, 1'b0);

      for (int b = 0; b < 150; b++) begin
         fill_rand();
         run_block("random", b[0], 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
